// File: rtl/en_delay_line_pkg.sv
// Shared helpers for en_delay_line: occupancy counter width.
// Latency: n/a; backpressure: n/a.
package en_delay_line_pkg;

    // Bits needed to count 0..depth inclusive; never narrower than 1.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/en_dff_stage.sv
// One enabled WIDTH+1-bit stage {valid, data} with valid-clear.
// Latency: 1 enabled edge; backpressure: en low holds, clr zeroes valid regardless of en.
module en_dff_stage
    import en_delay_line_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             v,
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t r;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r <= '0;
        end else begin
            if (en) begin
                r.data <= d;
            end
            // Clear wins over a shift so a flushed edge never admits a valid.
            if (clr) begin
                r.valid <= 1'b0;
            end else if (en) begin
                r.valid <= v;
            end
        end
    end

    assign q  = r.data;
    assign qv = r.valid;

endmodule

// File: rtl/en_delay_line.sv
// WIDTH x DEPTH enabled delay line with per-stage valid, flush and occupancy count.
// Latency: DEPTH enabled edges; backpressure: En low holds everything. Optional checks: EN_DELAY_LINE_ASSERT_EN.
module en_delay_line
    import en_delay_line_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Din,
    input  logic             Vin,
    input  logic             En,
    input  logic             Flush,
    output logic [WIDTH-1:0] Dout,
    output logic             Vout,
    output logic [CW-1:0]    Count
);

    logic [WIDTH-1:0] stage_dat [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        if (k == 0) begin : g_head
            assign d_in = Din;
            assign v_in = Vin;
        end else begin : g_body
            assign d_in = stage_dat[k-1];
            assign v_in = stage_vld[k-1];
        end
        en_dff_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK (CLK),
            .RST (RST),
            .en  (En),
            .clr (Flush),
            .d   (d_in),
            .v   (v_in),
            .q   (stage_dat[k]),
            .qv  (stage_vld[k])
        );
    end

    assign Dout = stage_dat[DEPTH-1];
    assign Vout = stage_vld[DEPTH-1];

    // Incremental count: entering valid adds one, departing valid (pre-edge Vout) removes one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Count <= '0;
        end else if (Flush) begin
            Count <= '0;
        end else if (En) begin
            if (Vin && !Vout) begin
                Count <= Count + CW'(1);
            end else if (!Vin && Vout) begin
                Count <= Count - CW'(1);
            end
        end
    end

`ifdef EN_DELAY_LINE_ASSERT_EN
    logic [DEPTH*WIDTH-1:0] dat_flat;
    int                     en_edges;

    always_comb begin
        dat_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dat_flat[i*WIDTH +: WIDTH] = stage_dat[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            en_edges <= 0;
        end else if (En && (en_edges < DEPTH)) begin
            en_edges <= en_edges + 1;
        end
    end

    a_count_max : assert property (@(posedge CLK) disable iff (RST)
        int'(Count) <= DEPTH);
    a_count_pop : assert property (@(posedge CLK) disable iff (RST)
        int'(Count) == $countones(stage_vld));
    a_hold : assert property (@(posedge CLK) disable iff (RST)
        (!En && !Flush) |=> ($stable(dat_flat) && $stable(stage_vld) && $stable(Count)));
    a_no_early_vout : assert property (@(posedge CLK) disable iff (RST)
        (en_edges < DEPTH) |-> !Vout);
`endif

endmodule

// File: tb/tb_en_delay_line.sv
// Directed checks of en_delay_line (DEPTH=4 and DEPTH=1 instances).
module tb_en_delay_line;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] Din;
    logic       Vin, En, Flush;
    logic [7:0] Dout;
    logic       Vout;
    logic [2:0] Count;

    logic [7:0] d1_Din;
    logic       d1_Vin, d1_En, d1_Flush;
    logic [7:0] d1_Dout;
    logic       d1_Vout;
    logic [0:0] d1_Count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    en_delay_line #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .Din(Din), .Vin(Vin), .En(En), .Flush(Flush),
        .Dout(Dout), .Vout(Vout), .Count(Count)
    );

    en_delay_line #(.WIDTH(8), .DEPTH(1)) dut1 (
        .CLK(CLK), .RST(RST), .Din(d1_Din), .Vin(d1_Vin), .En(d1_En), .Flush(d1_Flush),
        .Dout(d1_Dout), .Vout(d1_Vout), .Count(d1_Count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; Din = '0; Vin = 1'b0; En = 1'b0; Flush = 1'b0;
        d1_Din = '0; d1_Vin = 1'b0; d1_En = 1'b0; d1_Flush = 1'b0;
        #2;
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_vout", 32'(Vout), 0);
        chk("rst_count", 32'(Count), 0);
        chk("rst_d1_count", 32'(d1_Count), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Latency: A5 enters at edge 1, exits after edge 4.
        En = 1'b1; Vin = 1'b1; Din = 8'hA5;
        step();
        chk("lat_e1_count", 32'(Count), 1);
        chk("lat_e1_vout", 32'(Vout), 0);
        Vin = 1'b0; Din = 8'h00;
        step();
        chk("lat_e2_vout", 32'(Vout), 0);
        step();
        chk("lat_e3_vout", 32'(Vout), 0);
        chk("lat_e3_count", 32'(Count), 1);
        step();
        chk("lat_e4_dout", 32'(Dout), 'hA5);
        chk("lat_e4_vout", 32'(Vout), 1);
        chk("lat_e4_count", 32'(Count), 1);
        step();
        chk("lat_e5_vout", 32'(Vout), 0);
        chk("lat_e5_count", 32'(Count), 0);

        // Stall: 11, 22 loaded, then five held cycles with garbage on the inputs.
        Vin = 1'b1; Din = 8'h11;
        step();
        Din = 8'h22;
        step();
        chk("stall_load_count", 32'(Count), 2);
        En = 1'b0; Din = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold_count", 32'(Count), 2);
            chk("stall_hold_vout", 32'(Vout), 0);
        end
        chk("stall_hold_s0", 32'(dut.stage_dat[0]), 'h22);
        En = 1'b1; Vin = 1'b0; Din = 8'h00;
        step();
        chk("stall_e3_vout", 32'(Vout), 0);
        step();
        chk("stall_e4_dout", 32'(Dout), 'h11);
        chk("stall_e4_vout", 32'(Vout), 1);
        chk("stall_e4_count", 32'(Count), 2);
        step();
        chk("stall_e5_dout", 32'(Dout), 'h22);
        chk("stall_e5_count", 32'(Count), 1);
        step();
        chk("stall_e6_vout", 32'(Vout), 0);
        chk("stall_e6_count", 32'(Count), 0);

        // Fill and saturate with 1..6.
        Vin = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            Din = 8'(i);
            step();
            chk("fill_count", 32'(Count), (i < 4) ? i : 4);
            if (i >= 4) begin
                chk("fill_dout", 32'(Dout), i - 3);
                chk("fill_vout", 32'(Vout), 1);
            end
        end

        // Flush while full: valid cleared, data still shifts.
        Flush = 1'b1; Vin = 1'b1; Din = 8'h77;
        step();
        chk("flush_count", 32'(Count), 0);
        chk("flush_vout", 32'(Vout), 0);
        chk("flush_s0_data", 32'(dut.stage_dat[0]), 'h77);
        chk("flush_dout_data", 32'(Dout), 'h04);
        Flush = 1'b0;

        // Three valid entries, then asynchronous reset mid-cycle.
        Din = 8'h31;
        step();
        step();
        step();
        chk("pre_rst_count", 32'(Count), 3);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_count", 32'(Count), 0);
        chk("async_rst_vout", 32'(Vout), 0);
        chk("async_rst_dout", 32'(Dout), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        Vin = 1'b0; Din = 8'h00;
        step();
        chk("empty_shift_count", 32'(Count), 0);
        Vin = 1'b1; Din = 8'h5A;
        step();
        chk("post_rst_count", 32'(Count), 1);
        chk("post_rst_s0", 32'(dut.stage_dat[0]), 'h5A);
        En = 1'b0; Vin = 1'b0;

        // DEPTH=1 instance.
        d1_En = 1'b1; d1_Vin = 1'b1; d1_Din = 8'h3C;
        step();
        chk("d1_dout", 32'(d1_Dout), 'h3C);
        chk("d1_vout", 32'(d1_Vout), 1);
        chk("d1_count_one", 32'(d1_Count), 1);
        d1_Vin = 1'b0;
        step();
        chk("d1_count_zero", 32'(d1_Count), 0);
        chk("d1_vout_zero", 32'(d1_Vout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
